audio_playback_ctrl: RTL and testbench
======================================

AUDIO_PLAYBACK_CTRL -- requirements
Module: audio_playback_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: sample-memory address width.
REQ-002 SHALL have parameter INIT_TIMEOUT, default 1000000: Clk cycles allowed for codec init before error.
REQ-003 SHALL have port Clk  input  1  system clock, single clock domain.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports play_start / play_stop  input  1 each  one-cycle command pulses.
REQ-006 SHALL have ports start_addr / end_addr  input  ADDR_W each  inclusive playback range, sampled on play_start.
REQ-007 SHALL have port loop_en  input  1  wrap at end_addr (LOOP_EN builds only).
REQ-008 SHALL have ports INIT  output  1 and INIT_FINISH  input  1  codec-init handshake to audio interface.
REQ-009 SHALL have port data_over  input  1  audio interface consumed current sample.
REQ-010 SHALL have port DATA  output  16  sample presented to audio interface.
REQ-011 SHALL have ports MEM_ADDR  output  ADDR_W, MEM_RD  output  1, MEM_VALID  input  1, MEM_RDATA  input  16  sample-memory read port.
REQ-012 SHALL have ports busy, done, init_err  output  1 each, and underrun_cnt  output  8.

Function
REQ-013 SHALL implement states IDLE, INIT_WAIT, READY, PLAY, ERR.
REQ-014 SHALL leave IDLE one cycle after reset release, enter INIT_WAIT, and hold INIT=1 throughout INIT_WAIT.
REQ-015 SHALL go INIT_WAIT->READY on INIT_FINISH=1 and deassert INIT in the same transition.
REQ-016 SHALL go INIT_WAIT->ERR with init_err=1 when INIT_TIMEOUT cycles elapse without INIT_FINISH; ERR exits only by reset.
REQ-017 SHALL, in READY on play_start with end_addr>=start_addr, latch both addresses, set rd pointer=start_addr, enter PLAY; play_start with end_addr<start_addr SHALL be ignored.
REQ-018 SHALL ignore play_start while in PLAY.
REQ-019 SHALL issue MEM_RD as a one-cycle pulse with MEM_ADDR=rd pointer, allow exactly one outstanding read, and accept MEM_VALID at any latency >=1 cycle.
REQ-020 SHALL hold a one-entry prefetch buffer and issue a read whenever the buffer is empty, no read is outstanding, and range is not exhausted.
REQ-021 SHALL detect data_over by rising edge; on each edge in PLAY, DATA<=buffer and buffer marked empty in the next cycle.
REQ-022 SHALL, on a data_over edge with empty buffer, drive DATA=0 and increment underrun_cnt, saturating at 255.
REQ-023 SHALL, when a buffer fill and a data_over edge coincide, forward MEM_RDATA directly to DATA and leave buffer empty.
REQ-024 SHALL increment rd pointer on each issued read; after reading end_addr the range is exhausted.
REQ-025 SHALL, when range exhausted, buffer empty and the last sample presented, pulse done for one cycle and return to READY.
REQ-026 SHALL, on play_stop in PLAY, return to READY next cycle, set DATA=0, discard buffer, and drop any in-flight MEM_VALID response.
REQ-027 SHALL give play_stop priority over play_start in the same cycle.
REQ-028 SHALL drive busy=1 exactly while in PLAY.

Reset
REQ-029 SHALL on Reset=1 force state IDLE, INIT=0, DATA=0, MEM_RD=0, MEM_ADDR=0, busy=0, done=0, init_err=0, underrun_cnt=0, buffer empty, timeout counter 0.
REQ-030 SHALL abandon any in-progress init or playback on reset mid-operation and restart init sequence after release.

Configuration
REQ-031 SHALL honour macro AUDIO_PLAYBACK_LOOP_EN: when defined and loop_en=1, after reading end_addr the rd pointer wraps to start_addr and playback continues without done.
REQ-032 SHALL, without AUDIO_PLAYBACK_LOOP_EN, ignore loop_en and always stop at end_addr per REQ-025.

Structure
REQ-033 SHALL take the state enumeration and sample width constant (16) from shared package audio_ctrl_pkg.
REQ-034 SHALL place prefetch buffer and read-issue logic in sub-module audio_fetch_buf.

Verification
REQ-035 Reset release, INIT_FINISH at cycle 50 -> INIT high cycles 1..50, READY at 51, init_err=0.
REQ-036 INIT_FINISH never asserted, INIT_TIMEOUT=100 -> ERR, init_err=1 at cycle ~101, INIT=0.
REQ-037 Play 0x10..0x13, mem latency 3, data_over every 20 cycles -> DATA sequence mem[0x10..0x13], done one pulse after fourth edge, underrun_cnt=0.
REQ-038 Mem latency 30, data_over every 10 cycles -> DATA=0 on starved edges, underrun_cnt counts them, saturates at 255 after long run.
REQ-039 LOOP_EN build, range 0x0..0x2, loop_en=1, 7 edges -> DATA mem[0],1,2,0,1,2,0, no done.
REQ-040 play_stop with read outstanding plus simultaneous play_start -> READY, DATA=0, late MEM_VALID ignored, busy=0.

Source files
------------

// File: rtl/audio_ctrl_pkg.sv
// Shared types for the audio playback controller.
// Build option: define AUDIO_PLAYBACK_LOOP_EN to enable looped playback.
package audio_ctrl_pkg;

    localparam int SAMPLE_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT_WAIT,
        S_READY,
        S_PLAY,
        S_ERR
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/audio_fetch_buf.sv
// One-entry sample prefetch buffer and memory read issue.
// Build option: AUDIO_PLAYBACK_LOOP_EN is resolved by the top into i_loop.
module audio_fetch_buf
    import audio_ctrl_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_run,
    input  logic                i_load,
    input  logic                i_flush,
    input  logic                i_take,
    input  logic                i_loop,
    input  logic [ADDR_W-1:0]   i_start_addr,
    input  logic [ADDR_W-1:0]   i_end_addr,
    input  logic                i_mem_valid,
    input  logic [SAMPLE_W-1:0] i_mem_rdata,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic                o_mem_rd,
    output logic                o_full,
    output logic [SAMPLE_W-1:0] o_buf,
    output logic                o_fill,
    output logic                o_pend,
    output logic                o_exh
);

    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W-1:0]   r_start;
    logic [ADDR_W-1:0]   r_end;
    logic [ADDR_W-1:0]   r_addr;
    logic [SAMPLE_W-1:0] r_buf;
    logic                r_rd;
    logic                r_full;
    logic                r_pend;
    logic                r_exh;
    logic                r_drop;
    logic                w_fill;
    logic                w_issue;

    assign w_fill  = i_run && r_pend && i_mem_valid;
    // r_drop: a stopped read is still in flight; wait for it before issuing
    assign w_issue = i_run && !i_flush && !r_full && !r_pend
                     && !r_drop && !r_exh;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr   <= '0;
            r_start <= '0;
            r_end   <= '0;
            r_addr  <= '0;
            r_buf   <= '0;
            r_rd    <= 1'b0;
            r_full  <= 1'b0;
            r_pend  <= 1'b0;
            r_exh   <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_rd <= w_issue;
            if (w_issue) begin
                r_addr <= r_ptr;
            end
            if (i_flush && r_pend && !i_mem_valid) begin
                r_drop <= 1'b1;
            end else if (i_mem_valid) begin
                r_drop <= 1'b0;
            end
            if (i_load) begin
                r_ptr   <= i_start_addr;
                r_start <= i_start_addr;
                r_end   <= i_end_addr;
                r_exh   <= 1'b0;
                r_full  <= 1'b0;
                r_pend  <= 1'b0;
            end else if (i_flush) begin
                r_full <= 1'b0;
                r_pend <= 1'b0;
            end else begin
                if (w_issue) begin
                    r_pend <= 1'b1;
                    if (r_ptr == r_end) begin
                        if (i_loop) begin
                            r_ptr <= r_start;
                        end else begin
                            r_exh <= 1'b1;
                        end
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end else if (w_fill) begin
                    r_pend <= 1'b0;
                end
                // a fill coinciding with a take is forwarded by the top
                if (i_take) begin
                    r_full <= 1'b0;
                end else if (w_fill) begin
                    r_full <= 1'b1;
                    r_buf  <= i_mem_rdata;
                end
            end
        end
    end

    assign o_mem_addr = r_addr;
    assign o_mem_rd   = r_rd;
    assign o_full     = r_full;
    assign o_buf      = r_buf;
    assign o_fill     = w_fill;
    assign o_pend     = r_pend;
    assign o_exh      = r_exh;

endmodule

// File: rtl/audio_playback_ctrl.sv
// Audio playback controller: codec init handshake and sample streaming.
// Build option: define AUDIO_PLAYBACK_LOOP_EN to honour loop_en.
module audio_playback_ctrl
    import audio_ctrl_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int INIT_TIMEOUT = 1000000
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                play_start,
    input  logic                play_stop,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [ADDR_W-1:0]   end_addr,
    input  logic                loop_en,
    output logic                INIT,
    input  logic                INIT_FINISH,
    input  logic                data_over,
    output logic [SAMPLE_W-1:0] DATA,
    output logic [ADDR_W-1:0]   MEM_ADDR,
    output logic                MEM_RD,
    input  logic                MEM_VALID,
    input  logic [SAMPLE_W-1:0] MEM_RDATA,
    output logic                busy,
    output logic                done,
    output logic                init_err,
    output logic [7:0]          underrun_cnt
);

    localparam int TW = $clog2(INIT_TIMEOUT + 1);

    state_t              r_state;
    state_t              w_next;
    logic [TW-1:0]       r_tcnt;
    logic                r_do_q;
    logic                r_done;
    logic [SAMPLE_W-1:0] r_data;
    logic [7:0]          r_und;
    logic                w_load;
    logic                w_tmo;
    logic                w_play;
    logic                w_stop;
    logic                w_edge;
    logic                w_take;
    logic                w_fin;
    logic                w_loop;
    logic                w_full;
    logic [SAMPLE_W-1:0] w_buf;
    logic                w_fill;
    logic                w_pend;
    logic                w_exh;

`ifdef AUDIO_PLAYBACK_LOOP_EN
    assign w_loop = loop_en;
`else
    assign w_loop = loop_en & 1'b0;
`endif

    assign w_tmo  = (r_tcnt == TW'(INIT_TIMEOUT - 1));
    assign w_play = (r_state == S_PLAY);
    assign w_stop = w_play && play_stop;
    assign w_edge = data_over && !r_do_q;
    assign w_fin  = w_exh && !w_full && !w_pend;
    assign w_take = w_play && w_edge && !play_stop && !w_fin;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        unique case (r_state)
            S_IDLE: w_next = S_INIT_WAIT;
            S_INIT_WAIT: begin
                if (INIT_FINISH) begin
                    w_next = S_READY;
                end else if (w_tmo) begin
                    w_next = S_ERR;
                end
            end
            S_READY: begin
                if (play_start && !play_stop
                    && (end_addr >= start_addr)) begin
                    w_next = S_PLAY;
                    w_load = 1'b1;
                end
            end
            S_PLAY: begin
                if (play_stop || w_fin) begin
                    w_next = S_READY;
                end
            end
            S_ERR:   w_next = S_ERR;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_tcnt <= '0;
            r_do_q <= 1'b0;
            r_done <= 1'b0;
            r_data <= '0;
            r_und  <= '0;
        end else begin
            r_tcnt <= (r_state == S_INIT_WAIT) ? r_tcnt + 1'b1 : '0;
            r_do_q <= data_over;
            r_done <= w_play && !play_stop && w_fin;
            if (w_stop) begin
                r_data <= '0;
            end else if (w_take) begin
                if (w_full) begin
                    r_data <= w_buf;
                end else if (w_fill) begin
                    r_data <= MEM_RDATA;
                end else begin
                    r_data <= '0;
                    r_und  <= sat_inc8(r_und);
                end
            end
        end
    end

    audio_fetch_buf #(
        .ADDR_W(ADDR_W)
    ) u_fetch (
        .i_clk        (Clk),
        .i_rst        (Reset),
        .i_run        (w_play),
        .i_load       (w_load),
        .i_flush      (w_stop),
        .i_take       (w_take),
        .i_loop       (w_loop),
        .i_start_addr (start_addr),
        .i_end_addr   (end_addr),
        .i_mem_valid  (MEM_VALID),
        .i_mem_rdata  (MEM_RDATA),
        .o_mem_addr   (MEM_ADDR),
        .o_mem_rd     (MEM_RD),
        .o_full       (w_full),
        .o_buf        (w_buf),
        .o_fill       (w_fill),
        .o_pend       (w_pend),
        .o_exh        (w_exh)
    );

    assign INIT         = (r_state == S_INIT_WAIT);
    assign busy         = w_play;
    assign init_err     = (r_state == S_ERR);
    assign done         = r_done;
    assign DATA         = r_data;
    assign underrun_cnt = r_und;

endmodule

// File: tb/tb_audio_playback_ctrl.sv
// Self-checking bench for audio_playback_ctrl with a behavioural memory.
// Define AUDIO_PLAYBACK_LOOP_EN to exercise looped playback.
module tb_audio_playback_ctrl;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        play_start = 1'b0;
    logic        play_stop = 1'b0;
    logic [15:0] start_addr = '0;
    logic [15:0] end_addr = '0;
    logic        loop_en = 1'b0;
    logic        INIT_FINISH = 1'b0;
    logic        data_over = 1'b0;
    logic        MEM_VALID = 1'b0;
    logic [15:0] MEM_RDATA = '0;
    logic        INIT;
    logic [15:0] DATA;
    logic [15:0] MEM_ADDR;
    logic        MEM_RD;
    logic        busy;
    logic        done;
    logic        init_err;
    logic [7:0]  underrun_cnt;

    int checks = 0;
    int errors = 0;
    logic [15:0] mem [0:255];
    int m_lat = 3;
    int m_cnt = 0;
    logic [7:0] m_addr = '0;
    int done_cnt = 0;
    int rd_cnt = 0;

    audio_playback_ctrl #(
        .ADDR_W(16),
        .INIT_TIMEOUT(100)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .play_start   (play_start),
        .play_stop    (play_stop),
        .start_addr   (start_addr),
        .end_addr     (end_addr),
        .loop_en      (loop_en),
        .INIT         (INIT),
        .INIT_FINISH  (INIT_FINISH),
        .data_over    (data_over),
        .DATA         (DATA),
        .MEM_ADDR     (MEM_ADDR),
        .MEM_RD       (MEM_RD),
        .MEM_VALID    (MEM_VALID),
        .MEM_RDATA    (MEM_RDATA),
        .busy         (busy),
        .done         (done),
        .init_err     (init_err),
        .underrun_cnt (underrun_cnt)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory with fixed response latency; one read in flight at a time
    always @(negedge Clk) begin
        MEM_VALID = 1'b0;
        if (done) done_cnt++;
        if (Reset) begin
            m_cnt = 0;
        end else begin
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    MEM_VALID = 1'b1;
                    MEM_RDATA = mem[m_addr];
                end
            end
            if (MEM_RD) begin
                rd_cnt++;
                chk("one_outstanding", m_cnt, 0);
                m_cnt  = m_lat;
                m_addr = MEM_ADDR[7:0];
            end
        end
    end

    task automatic reset_checks();
        chk("rst_INIT", INIT, 0);
        chk("rst_DATA", DATA, 0);
        chk("rst_MEM_RD", MEM_RD, 0);
        chk("rst_MEM_ADDR", MEM_ADDR, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_init_err", init_err, 0);
        chk("rst_underrun", underrun_cnt, 0);
    endtask

    task automatic init_seq();
        int hi = 0;
        Reset = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            @(negedge Clk);
            if (INIT === 1'b1) hi++;
        end
        INIT_FINISH = 1'b1;
        @(negedge Clk);
        INIT_FINISH = 1'b0;
        chk("init_high_cycles", hi, 50);
        chk("init_low_in_ready", INIT, 0);
        chk("init_err_clear", init_err, 0);
    endtask

    task automatic start_play(input logic [15:0] s, input logic [15:0] e);
        start_addr = s;
        end_addr   = e;
        play_start = 1'b1;
        @(negedge Clk);
        play_start = 1'b0;
    endtask

    task automatic pulse_edge();
        data_over = 1'b1;
        @(negedge Clk);
        data_over = 1'b0;
    endtask

    // Model: each edge presents the next sample of the range in order,
    // or 0 when starved; starved edges add to a counter saturating at 255.
    task automatic run_play(input int s, input int e, input int lat,
                            input int period, input int maxe,
                            output int zeros);
        int idx;
        int edges;
        int d0;
        int base;
        int exp_u;
        logic [15:0] obs;
        m_lat = lat;
        base  = int'(underrun_cnt);
        d0    = done_cnt;
        zeros = 0;
        edges = 0;
        idx   = s;
        start_play(16'(s), 16'(e));
        chk("busy_in_play", busy, 1);
        while (done_cnt == d0 && edges < maxe) begin
            repeat (period - 1) @(negedge Clk);
            if (done_cnt != d0) break;
            pulse_edge();
            edges++;
            obs = DATA;
            if (obs == 16'h0) begin
                zeros++;
            end else if (idx <= e) begin
                chk("sample", obs, mem[idx]);
                idx++;
            end else begin
                chk("extra_sample", obs, 0);
            end
        end
        repeat (4) @(negedge Clk);
        exp_u = (base + zeros > 255) ? 255 : base + zeros;
        chk("all_samples", idx, e + 1);
        chk("done_once", done_cnt - d0, 1);
        chk("busy_after_done", busy, 0);
        chk("underrun_cnt", underrun_cnt, exp_u);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int z;
        int r0;
        int d0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'($urandom_range(65535, 1));
        end

        #2 Reset = 1'b1;
        repeat (3) @(negedge Clk);
        reset_checks();

        // Init timeout into ERR
        begin
            int hi = 0;
            Reset = 1'b0;
            for (int c = 0; c < 300; c++) begin
                @(negedge Clk);
                if (init_err === 1'b1) break;
                if (INIT === 1'b1) hi++;
            end
            chk("tmo_init_cycles", hi, 100);
            chk("tmo_init_err", init_err, 1);
            chk("tmo_INIT_low", INIT, 0);
            start_play(16'h1, 16'h2);
            @(negedge Clk);
            chk("err_sticky", init_err, 1);
            chk("err_no_play", busy, 0);
        end

        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        reset_checks();
        init_seq();

        // Reversed range is ignored
        r0 = rd_cnt;
        start_play(16'h20, 16'h1F);
        repeat (3) @(negedge Clk);
        chk("bad_range_busy", busy, 0);
        chk("bad_range_no_rd", rd_cnt - r0, 0);

        run_play(16'h10, 16'h13, 3, 20, 10, z);
        chk("no_underrun", z, 0);

        for (int k = 0; k < 3; k++) begin
            int s;
            s = int'($urandom_range(200, 0));
            run_play(s, s + int'($urandom_range(7, 0)),
                     int'($urandom_range(6, 1)), 12, 40, z);
        end

        // Stop with a read in flight, start in the same cycle
        m_lat = 2;
        start_play(16'h30, 16'h35);
        repeat (10) @(negedge Clk);
        m_lat = 20;
        r0 = rd_cnt;
        pulse_edge();
        chk("stop_pre_data", DATA, mem[8'h30]);
        repeat (3) @(negedge Clk);
        chk("stop_rd_inflight", rd_cnt - r0, 1);
        play_stop  = 1'b1;
        play_start = 1'b1;
        start_addr = 16'h40;
        end_addr   = 16'h41;
        @(negedge Clk);
        play_stop  = 1'b0;
        play_start = 1'b0;
        chk("stop_busy", busy, 0);
        chk("stop_data", DATA, 0);
        @(negedge Clk);
        chk("stop_stays_ready", busy, 0);
        run_play(16'h20, 16'h22, 2, 30, 20, z);

`ifdef AUDIO_PLAYBACK_LOOP_EN
        loop_en = 1'b1;
        m_lat   = 2;
        d0      = done_cnt;
        start_play(16'h0, 16'h2);
        for (int i = 0; i < 7; i++) begin
            repeat (19) @(negedge Clk);
            pulse_edge();
            chk("loop_sample", DATA, mem[i % 3]);
        end
        chk("loop_no_done", done_cnt - d0, 0);
        chk("loop_busy", busy, 1);
        play_stop = 1'b1;
        @(negedge Clk);
        play_stop = 1'b0;
        chk("loop_stopped", busy, 0);
        loop_en = 1'b0;
        repeat (30) @(negedge Clk);
`else
        loop_en = 1'b1;
        run_play(16'h0, 16'h2, 2, 20, 10, z);
        loop_en = 1'b0;
`endif

        // Starved playback saturates the underrun counter
        run_play(16'h0, 16'd199, 30, 10, 1000, z);
        chk("starved_edges", z > 0, 1);
        chk("underrun_sat", underrun_cnt, 255);

        // Reset mid-playback restarts init
        m_lat = 5;
        start_play(16'h50, 16'h60);
        repeat (30) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        reset_checks();
        repeat (2) @(negedge Clk);
        init_seq();
        run_play(16'h70, 16'h72, 4, 15, 10, z);
        chk("final_no_underrun", z, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
